rr_mux: RTL
===========

Name: rr_mux

Overview:
Parametrised N:1 multiplexer with a registered output and valid/ready handshakes on every input channel and on the output. It is the channel-count- and mode-generalised successor of the 2:1 MUX. It selects either a software-chosen channel (fixed mode) or arbitrates fairly among the requesting channels (round-robin mode). It sits between multiple producers (register file read ports, ALU, immediate path, memory return) and a single consumer stage of the datapath.

Parameters:
DATA_WIDTH, `DATA_WIDTH (16), width of each data word
NUM_CH, 4, number of input channels (2..16)
SEL_WIDTH, $clog2(NUM_CH), width of the channel index

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Mode  input  1  0 = fixed select via Sel; 1 = round-robin arbitration
Sel  input  SEL_WIDTH  channel index used when Mode=0
In_Data  input  NUM_CH*DATA_WIDTH  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
In_Valid  input  NUM_CH  per-channel valid
In_Ready  output  NUM_CH  per-channel ready; at most one bit high
Out_Data  output  DATA_WIDTH  registered selected word
Out_Ch  output  SEL_WIDTH  index of the channel that supplied Out_Data
Out_Valid  output  1  Out_Data/Out_Ch hold a word
Out_Ready  input  1  consumer accepts the word

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Reset sampled on the rising edge of Clk).
- Reset values: Out_Valid=0, Out_Data=0, Out_Ch=0, internal round-robin pointer Ptr=0. In_Ready=0 during the Reset cycle.
- Load_En = !Out_Valid | Out_Ready. The output stage accepts a new word on any cycle with Load_En.
- Grant, Mode=0: G=Sel. The grant is valid only if Sel<NUM_CH and In_Valid[Sel]=1. Sel>=NUM_CH gives no grant and is not an error.
- Grant, Mode=1: G is the first i with In_Valid[i]=1, scanning Ptr, Ptr+1, ... and wrapping modulo NUM_CH. No valid input gives no grant.
- In_Ready[G]=Load_En & grant_valid. All other bits are 0. In_Ready is combinational from In_Valid/Mode/Sel/Ptr/Out_Valid/Out_Ready. In_Ready never depends on In_Data.
- Transfer on channel G occurs when In_Valid[G] & In_Ready[G]. On the next edge: Out_Data<=In_Data[G], Out_Ch<=G, Out_Valid<=1.
- Load_En with no transfer: Out_Valid<=0. Out_Data and Out_Ch hold their values.
- Out_Valid=1 & Out_Ready=0: Out_Data, Out_Ch and Out_Valid hold. All In_Ready bits are 0 (stall).
- Latency: 1 cycle input-to-output. Throughput: 1 word per cycle with Out_Ready held high.
- Ptr: on a transfer with Mode=1, Ptr<=(G+1) mod NUM_CH, with wrap from NUM_CH-1 to 0. Ptr is unchanged in Mode=0 and on cycles with no transfer.
- Mode/Sel changes are sampled every cycle and take effect on the same cycle's grant. A word already held in the output register is unaffected.
- Reset asserted mid-operation takes priority over all else. A held output word is discarded and Ptr returns to 0.
- No data width conversion, no parity, no error flags.

Decomposition:
- Shared parameters file (parameters.v) gains `NUM_MUX_CH (4), `MUX_MODE_FIXED (1'b0) and `MUX_MODE_RR (1'b1). It keeps the existing `DATA_WIDTH, `PERIOD and `NUM_MUX_TEST.
- One sub-module is natural: rr_arbiter (inputs Req[NUM_CH], Ptr; outputs Grant index and Grant_Valid), pure combinational rotate-priority.
- rr_mux contains the mode select, the Ptr register, the output register and the handshake logic.

Test Plan:
- Reset: Reset=1 for 2 cycles with all In_Valid=1 -> Out_Valid=0, Out_Data=0, Out_Ch=0, In_Ready=4'b0000. On the first cycle after release in Mode=1, In_Ready=4'b0001.
- Fixed mode: Mode=0, Sel=2, In_Valid=4'b1111, ch0..3 data=10,20,30,40, Out_Ready=1 -> Out_Data=30 and Out_Ch=2 every cycle; Sel=3 gives Out_Data=40 one cycle later; In_Valid[2]=0 with Sel=2 gives Out_Valid=0.
- Round-robin fairness: Mode=1, In_Valid=4'b1111, data 10,20,30,40, Out_Ready=1 for 8 cycles -> Out_Ch sequence 0,1,2,3,0,1,2,3 (Ptr wraps 3->0).
- Sparse requests: Mode=1, Ptr=0, In_Valid=4'b1010 -> Out_Ch 1,3,1,3. Dropping In_Valid to 4'b0000 gives Out_Valid=0 on the next cycle.
- Backpressure: Out_Valid=1, Out_Data=20, Out_Ready=0 for 3 cycles while inputs change -> Out_Data=20, Out_Ch=1 stable, In_Ready=0. When Out_Ready rises, the next channel (Ch 2) loads in the same cycle the old word leaves.
- Reset mid-stream: during the round-robin run, assert Reset with Out_Valid=1 and Ptr=3 -> next cycle Out_Valid=0, Out_Data=0. After release the first grant is channel 0.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin / fixed-select output mux.
// Users import rr_mux_pkg::* so that defaults and mode encodings stay consistent.
package rr_mux_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int NUM_MUX_CH     = 4;

  typedef enum logic {
    MUX_MODE_FIXED = 1'b0,
    MUX_MODE_RR    = 1'b1
  } mux_mode_e;

endpackage

// File: rtl/rr_mux_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester found
// when scanning upward from Ptr and wrapping modulo NUM_CH.
module rr_mux_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    Req,
  input  logic [SEL_WIDTH-1:0] Ptr,
  output logic [SEL_WIDTH-1:0] Grant,
  output logic                 Grant_Valid
);

  localparam logic [SEL_WIDTH:0] NCH = NUM_CH[SEL_WIDTH:0];

  logic [SEL_WIDTH:0]   sum;
  logic [SEL_WIDTH-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    Grant       = '0;
    Grant_Valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum = {1'b0, Ptr} + (SEL_WIDTH + 1)'(k);
      if (sum >= NCH) begin
        sum = sum - NCH;
      end
      idx = sum[SEL_WIDTH-1:0];
      if (Req[idx]) begin
        Grant       = idx;
        Grant_Valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N:1 mux with registered output and valid/ready handshakes, selecting either
// a software-chosen channel (Mode=0) or arbitrating round-robin (Mode=1).
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = NUM_MUX_CH,
  parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Mode,
  input  logic [SEL_WIDTH-1:0]         Sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0] In_Data,
  input  logic [NUM_CH-1:0]            In_Valid,
  output logic [NUM_CH-1:0]            In_Ready,
  output logic [DATA_WIDTH-1:0]        Out_Data,
  output logic [SEL_WIDTH-1:0]         Out_Ch,
  output logic                         Out_Valid,
  input  logic                         Out_Ready
);

  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(NUM_CH - 1);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]  out_ch_q, out_ch_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;

  logic [SEL_WIDTH-1:0]  rr_grant;
  logic                  rr_grant_valid;
  logic                  fix_grant_valid;
  logic [SEL_WIDTH-1:0]  grant;
  logic                  grant_valid;
  logic                  load_en;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  rr_mux_arbiter #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arbiter (
    .Req         (In_Valid),
    .Ptr         (ptr_q),
    .Grant       (rr_grant),
    .Grant_Valid (rr_grant_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]  = In_Data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign In_Ready[gi] = xfer && (grant == SEL_WIDTH'(gi));
    end
  endgenerate

  // An out-of-range Sel simply matches no channel, so it yields no grant.
  always_comb begin
    fix_grant_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (Sel == SEL_WIDTH'(i)) begin
        fix_grant_valid = In_Valid[i];
      end
    end
  end

  always_comb begin
    if (Mode == MUX_MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end else begin
      grant       = Sel;
      grant_valid = fix_grant_valid;
    end
  end

  assign load_en = !out_valid_q || Out_Ready;
  assign xfer    = load_en && grant_valid && !Reset;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        sel_data = ch_data[i];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = sel_data;
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (Mode == MUX_MODE_RR) begin
        ptr_d = (grant == LAST_CH) ? '0 : grant + 1'b1;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Out_Data  = out_data_q;
  assign Out_Ch    = out_ch_q;
  assign Out_Valid = out_valid_q;

endmodule
